// File: rtl/lc3_bus_driver.sv
// Registered priority bus driver: lowest enabled source drives bus one cycle later, value held while idle; no backpressure.
// Optional contention detect/sticky/saturating counter under `LC3_BUS_CONTENTION_CHECK_EN (default: disabled, tied to 0).
module lc3_bus_driver #(
  parameter int WIDTH    = 16,
  parameter int NSRC     = 4,
  parameter int ERRCNT_W = 8,
  localparam int OW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ena,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      bus,
  output logic                  bus_valid,
  output logic [OW-1:0]         bus_owner,
  output logic                  bus_idle,
  output logic                  contention,
  output logic                  err_sticky,
  output logic [ERRCNT_W-1:0]   err_count
);

  logic [OW-1:0]    sel;
  logic [WIDTH-1:0] sel_data;
  logic             any_ena;

  // Descending scan so the lowest enabled index is the last to write.
  always_comb begin
    sel      = '0;
    sel_data = '0;
    any_ena  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_ena[i]) begin
        sel      = OW'(i);
        sel_data = src_data[i*WIDTH +: WIDTH];
        any_ena  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus       <= '0;
      bus_owner <= '0;
      bus_valid <= 1'b0;
      bus_idle  <= 1'b1;
    end else begin
      if (any_ena) begin
        bus       <= sel_data;
        bus_owner <= sel;
      end
      bus_valid <= any_ena;
      bus_idle  <= !any_ena;
    end
  end

`ifdef LC3_BUS_CONTENTION_CHECK_EN
  logic multi_ena;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_ena = |(src_ena & (src_ena - NSRC'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      contention <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      contention <= multi_ena;
      if (multi_ena) begin
        err_sticky <= 1'b1;
        if (clr_err)
          err_count <= ERRCNT_W'(1);
        else if (err_count != {ERRCNT_W{1'b1}})
          err_count <= err_count + ERRCNT_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign contention     = 1'b0;
  assign err_sticky     = 1'b0;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_lc3_bus_driver.sv
// Bench for lc3_bus_driver: directed plan steps then random traffic against a behavioural model (default and ERRCNT_W=2 instances).
module tb_lc3_bus_driver;

`ifdef LC3_BUS_CONTENTION_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] src_data;
  logic [3:0]  src_ena;
  logic        clr_err;

  logic [15:0] bus, s_bus;
  logic        bus_valid, s_valid;
  logic [1:0]  bus_owner, s_owner;
  logic        bus_idle, s_idle;
  logic        contention, s_cont;
  logic        err_sticky, s_sticky;
  logic [7:0]  err_count;
  logic [1:0]  s_count;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [15:0] m_bus;
  int          m_owner;
  bit          m_valid, m_idle, m_cont, m_sticky;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  lc3_bus_driver dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_ena(src_ena), .clr_err(clr_err),
    .bus(bus), .bus_valid(bus_valid), .bus_owner(bus_owner), .bus_idle(bus_idle),
    .contention(contention), .err_sticky(err_sticky), .err_count(err_count)
  );

  lc3_bus_driver #(.WIDTH(16), .NSRC(4), .ERRCNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .src_data(src_data), .src_ena(src_ena), .clr_err(clr_err),
    .bus(s_bus), .bus_valid(s_valid), .bus_owner(s_owner), .bus_idle(s_idle),
    .contention(s_cont), .err_sticky(s_sticky), .err_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] e, input logic c);
    reset   = r;
    src_ena = e;
    clr_err = c;
  endtask

  task automatic set_src(input int i, input logic [15:0] v);
    src_data[i*16 +: 16] = v;
  endtask

  // Spec rules: lowest enabled index wins, 2+ enables is contention, counters saturate.
  task automatic model_edge();
    int n, first;
    n = 0;
    first = -1;
    for (int i = 0; i < 4; i++)
      if (src_ena[i]) begin
        n++;
        if (first < 0) first = i;
      end
    if (reset) begin
      m_bus = 0; m_owner = 0; m_valid = 0; m_idle = 1;
      m_cont = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (n > 0) begin
        m_bus   = src_data[first*16 +: 16];
        m_owner = first;
      end
      m_valid = (n > 0);
      m_idle  = (n == 0);
      m_cont  = CHK && (n >= 2);
      if (CHK) begin
        if (m_cont) begin
          m_sticky = 1;
          m_cnt  = clr_err ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
          m_cnt2 = clr_err ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
        end else if (clr_err) begin
          m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("bus",        32'(bus),        32'(m_bus));
    chk("bus_owner",  32'(bus_owner),  32'(m_owner));
    chk("bus_valid",  32'(bus_valid),  32'(m_valid));
    chk("bus_idle",   32'(bus_idle),   32'(m_idle));
    chk("contention", 32'(contention), 32'(m_cont));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_count",  32'(err_count),  32'(m_cnt));
    chk("sat_bus",    32'(s_bus),      32'(m_bus));
    chk("sat_sticky", 32'(s_sticky),   32'(m_sticky));
    chk("sat_count",  32'(s_count),    32'(m_cnt2));
  endtask

  initial begin
    src_data = 64'h0;
    drive(1'b1, 4'b1111, 1'b1);
    src_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    tick();
    chk("reset_idle_const", 32'(bus_idle), 32'd1);

    // Single source, then hold.
    drive(1'b0, 4'b0100, 1'b0);
    set_src(2, 16'h1234);
    tick();
    chk("single_bus_const", 32'(bus), 32'h1234);
    chk("single_owner_const", 32'(bus_owner), 32'd2);
    drive(1'b0, 4'b0000, 1'b0);
    src_data = 64'h1111_2222_3333_4444;
    tick();
    tick();
    chk("hold_bus_const", 32'(bus), 32'h1234);

    // Contention: source 1 wins over source 3.
    set_src(1, 16'hAAAA);
    set_src(3, 16'h5555);
    drive(1'b0, 4'b1010, 1'b0);
    tick();
    chk("cont_bus_const", 32'(bus), 32'hAAAA);
    drive(1'b0, 4'b0000, 1'b0);
    tick();
    chk("cont_pulse_end", 32'(contention), 32'd0);

    // Clear alone, then saturation on the 2-bit instance.
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 4'b0011, 1'b0);
    for (int k = 0; k < 5; k++) tick();

    // Clear together with contention, then clear alone.
    drive(1'b0, 4'b0110, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 1'b1);
    tick();

    // Back-to-back sources 0, 3, 2 then reset mid-sequence with contention.
    src_data = 64'h0303_0202_0101_0000;
    drive(1'b0, 4'b0001, 1'b0);
    tick();
    drive(1'b0, 4'b1000, 1'b0);
    tick();
    drive(1'b0, 4'b0100, 1'b0);
    tick();
    drive(1'b0, 4'b0011, 1'b0);
    tick();
    drive(1'b1, 4'b1101, 1'b1);
    tick();
    drive(1'b0, 4'b1000, 1'b0);
    tick();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      src_data = {$urandom, $urandom};
      drive(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) src_ena = 4'b0000;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
